// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-tick divider and registered sync/blank/strobes
// Define VGA_TIMING_FRAME_COUNT_EN to build the 16-bit frame_count register; otherwise it is tied to zero.
module vga_timing_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COUNT_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               pixel_tick,
  output logic [COUNT_W-1:0] pixel_x,
  output logic [COUNT_W-1:0] pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [15:0]        frame_count
);
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_VIS    = COUNT_W'(H_DISPLAY);
  localparam logic [COUNT_W-1:0] V_VIS    = COUNT_W'(V_DISPLAY);
  localparam logic [COUNT_W-1:0] HS_FIRST = COUNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [COUNT_W-1:0] HS_LAST  = COUNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VS_FIRST = COUNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [COUNT_W-1:0] VS_LAST  = COUNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [COUNT_W-1:0] h_q, h_d, v_q, v_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
  logic               line_q, line_d, frame_q, frame_d;
  logic               h_wrap, v_wrap;

  assign pixel_tick = en && div_q == DIV_LAST;
  assign h_wrap     = h_q == H_LAST;
  assign v_wrap     = v_q == V_LAST;

  always_comb begin
    div_d   = en ? (pixel_tick ? '0 : div_q + 1'b1) : div_q;
    h_d     = pixel_tick ? (h_wrap ? '0 : h_q + 1'b1) : h_q;
    v_d     = pixel_tick && h_wrap ? (v_wrap ? '0 : v_q + 1'b1) : v_q;
    hsync_d = h_q >= HS_FIRST && h_q <= HS_LAST ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = v_q >= VS_FIRST && v_q <= VS_LAST ? VSYNC_POL : ~VSYNC_POL;
    video_d = h_q < H_VIS && v_q < V_VIS;
    line_d  = pixel_tick && h_wrap;
    frame_d = line_d && v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      video_q <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  assign fcnt_d = frame_d ? fcnt_q + 16'd1 : fcnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end
  assign frame_count = fcnt_q;
`else
  assign frame_count = 16'd0;
`endif

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a small raster (H 4/1/2/1, V 3/1/1/1, CLK_DIV 3)
module tb_vga_timing_gen;
  localparam int CD = 3, HT = 8, VT = 6;

  logic clk = 1'b0, reset, en;
  logic pixel_tick, hsync, vsync, video_on, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [15:0] frame_count;

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(CD), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COUNT_W(10)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .pixel_tick(pixel_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x, y;
    logic        hs, vs, vo, ls, fs;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int m_div, m_h, m_v, m_fc;
  int cyc, first_fs, n_fs;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_h = 0; m_v = 0; m_fc = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, int'(pixel_x), 0);
    chk({tag, "_y"}, int'(pixel_y), 0);
    chk({tag, "_hsync"}, int'(hsync), 0);
    chk({tag, "_vsync"}, int'(vsync), 1);
    chk({tag, "_video_on"}, int'(video_on), 0);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_frame_count"}, int'(frame_count), 0);
    chk({tag, "_tick"}, int'(pixel_tick), 0);
  endtask

  task automatic cycle(input logic e);
    exp_t ex, got;
    logic t;
    @(negedge clk);
    en = e;
    #1;
    t = e && m_div == CD - 1;
    chk("pixel_tick", int'(pixel_tick), int'(t));
    ex.hs = m_h >= 5 && m_h <= 6;
    ex.vs = !(m_v == 4);
    ex.vo = m_h < 4 && m_v < 3;
    ex.ls = t && m_h == HT - 1;
    ex.fs = ex.ls && m_v == VT - 1;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    if (ex.fs) m_fc = (m_fc + 1) % 65536;
`endif
    ex.fc = 16'(m_fc);
    if (e) m_div = t ? 0 : m_div + 1;
    if (t) begin
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else m_h++;
    end
    ex.x = 10'(m_h);
    ex.y = 10'(m_v);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    cyc++;
    got = sb.pop_front();
    chk("pixel_x", int'(pixel_x), int'(got.x));
    chk("pixel_y", int'(pixel_y), int'(got.y));
    chk("hsync", int'(hsync), int'(got.hs));
    chk("vsync", int'(vsync), int'(got.vs));
    chk("video_on", int'(video_on), int'(got.vo));
    chk("line_start", int'(line_start), int'(got.ls));
    chk("frame_start", int'(frame_start), int'(got.fs));
    chk("frame_count", int'(frame_count), int'(got.fc));
    if (frame_start) begin
      n_fs++;
      if (first_fs < 0) first_fs = cyc;
    end
  endtask

  initial begin
    bit hit;
    reset = 1'b1;
    en = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("in_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0; first_fs = -1; n_fs = 0;
    for (int i = 0; i < 2 * HT * VT * CD + 10; i++) cycle(1'b1);
    chk("frames_run1", n_fs, 2);

    hit = 0;
    for (int i = 0; i < HT * VT * CD && !hit; i++) begin
      if (m_h == 3 && m_div == 1) hit = 1;
      else cycle(1'b1);
    end
    chk("reach_midline", int'(hit), 1);
    for (int i = 0; i < 100; i++) cycle(1'b0);
    chk("hold_x", int'(pixel_x), 3);
    for (int i = 0; i < 2 * CD; i++) cycle(1'b1);

    hit = 0;
    for (int i = 0; i < HT * VT * CD && !hit; i++) begin
      if (m_v == 2 && m_h == 5) hit = 1;
      else cycle(1'b1);
    end
    chk("reach_midframe", int'(hit), 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("async_reset");
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0; first_fs = -1; n_fs = 0;
    for (int i = 0; i < 3 * HT * VT * CD + 5; i++) cycle(1'b1);
    chk("first_frame_start", first_fs, HT * VT * CD);
    chk("frames_run2", n_fs, 3);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk("frame_count_3", int'(frame_count), 3);
`else
    chk("frame_count_tied", int'(frame_count), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator; successor to the fixed 640x480 controller. Divides the system clock into a pixel tick, runs horizontal and vertical raster counters, and produces registered sync, blanking, and line/frame strobes. Sits between the system clock domain and the pixel/sprite renderers (snake, food, score), which consume `pixel_x`/`pixel_y`/`video_on` and sample game state on `frame_start`.

## Interface
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `CLK_DIV`, 4: clk cycles per pixel; legal values are 1 or greater.
- `HSYNC_POL`, 0: 0 = active-low hsync, 1 = active-high.
- `VSYNC_POL`, 0: 0 = active-low vsync, 1 = active-high.
- `COUNT_W`, 10: counter width. Requires H_TOTAL ≤ 2^COUNT_W and V_TOTAL ≤ 2^COUNT_W.
- `clk`  in  1  system clock (100 MHz nominal).
- `reset`  in  1  reset, asynchronous, active-high.
- `en`  in  1  run enable; when low, the divider and counters freeze.
- `pixel_tick`  out  1  one-clk strobe marking each pixel period.
- `pixel_x`  out  COUNT_W  horizontal count, 0..H_TOTAL-1.
- `pixel_y`  out  COUNT_W  vertical count, 0..V_TOTAL-1.
- `hsync`  out  1  registered, polarity set by HSYNC_POL.
- `vsync`  out  1  registered, polarity set by VSYNC_POL.
- `video_on`  out  1  registered; high inside the visible area.
- `line_start`  out  1  one-clk pulse when pixel_x wraps to 0.
- `frame_start`  out  1  one-clk pulse when (pixel_x, pixel_y) wraps to (0, 0).
- `frame_count`  out  16  frames completed since reset; see Configuration.

## Operation
- H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK. V_TOTAL is the same sum over the V_ parameters.
- Divider `div_cnt` counts 0..CLK_DIV-1 and advances when `en`=1. `pixel_tick` is combinational: `en` AND `div_cnt`==CLK_DIV-1. With CLK_DIV=1, `pixel_tick`=`en`.
- On `pixel_tick`:
  - `h_cnt` increments, wrapping H_TOTAL-1 → 0.
  - On the same wrap, `v_cnt` increments, wrapping V_TOTAL-1 → 0.
- `pixel_x`=`h_cnt` and `pixel_y`=`v_cnt`, driven directly from the counter registers.
- `hsync` register is loaded every clk with the active level when H_DISPLAY+H_FRONT ≤ `h_cnt` ≤ H_DISPLAY+H_FRONT+H_SYNC-1, and with the inactive level otherwise.
- `vsync` register uses the same rule over the V_ parameters with `v_cnt`.
- `video_on` register is loaded every clk with (`h_cnt` < H_DISPLAY) AND (`v_cnt` < V_DISPLAY).
- `line_start` register is loaded with `pixel_tick` AND `h_cnt`==H_TOTAL-1. It is therefore high in the first clk where `pixel_x`=0.
- `frame_start` register is loaded with `line_start`'s condition AND `v_cnt`==V_TOTAL-1.
- When `en` is low, all counters hold. Registered outputs keep re-evaluating from the held counters, so they stay constant. Strobes are 0.
- Reset, asynchronous and taking effect at any time including mid-frame:
  - `div_cnt`, `h_cnt`, `v_cnt` and `frame_count` go to 0.
  - `hsync` and `vsync` go to their inactive levels (1 when POL=0).
  - `video_on`, `line_start` and `frame_start` go to 0.
  - The raster restarts at (0, 0) with no partial-frame `frame_start`.

## Timing
- With `en` held high from reset release, the first `pixel_tick` occurs in clk cycle CLK_DIV-1 (0-based). After that it repeats every CLK_DIV clks.
- `pixel_x`/`pixel_y` update on the clk edge that samples `pixel_tick`.
- `hsync`, `vsync` and `video_on` lag the counters by exactly 1 clk. Downstream logic registering pixel colour for 1 clk stays aligned with them.
- Frame period is H_TOTAL × V_TOTAL × CLK_DIV clks. With defaults this is 1,680,000 clks, which is 59.52 Hz at 100 MHz.
- `frame_start` implies `line_start` in the same clk.

## Configuration
- `VGA_TIMING_FRAME_COUNT_EN` defined:
  - `frame_count` is a 16-bit register, reset to 0.
  - It increments on the same edge that sets `frame_start` and wraps 65535 → 0.
- Not defined: `frame_count` is tied to 16'd0 and no register is synthesised.

## Test plan
- Defaults, `en`=1, release reset: `pixel_tick` high in clk cycles 3, 7, 11, … `pixel_x` reads 0, 1, 2 after ticks 1, 2, 3. `hsync` stays 1 and `video_on` stays 0 during reset.
- Defaults, full line: `hsync` goes low 1 clk after `pixel_x` becomes 656 and returns high 1 clk after `pixel_x` becomes 752. `video_on` falls 1 clk after `pixel_x`=640. `line_start` pulses when `pixel_x` goes 799 → 0 and `pixel_y` increments.
- Defaults, full frame: `vsync` is low exactly while `pixel_y`=490..491, delayed 1 clk. `frame_start` pulses once per 1,680,000 clks. With the macro, `frame_count` reads 3 after three frames.
- Small config H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, HSYNC_POL=1: H_TOTAL=8 and `hsync` is high for `pixel_x`=5..6. V_TOTAL=6 gives a frame of 48 clks.
- `en`=0 for 100 clks mid-line (`pixel_x`=300): no tick, `pixel_x` stays 300, strobes stay 0. Resume: the next tick arrives CLK_DIV-`div_cnt` clks later.
- Assert `reset` asynchronously mid-frame (`pixel_y`=200): all outputs return to reset values immediately. After release, the raster restarts at (0, 0) and the first `frame_start` occurs one full frame later.
